// File: rtl/mips_mc_core_if.sv
// Shared memory port between the multi-cycle MIPS core (master) and a unified memory (slave).
// A transfer completes in any cycle where req and ready are both high.
interface mips_mc_core_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mips_mc_core.sv
// Multi-cycle 32-bit MIPS core: FETCH/DECODE/EXEC/MEM/WB sequenced over one shared memory port,
// with run gating in IDLE, a retire pulse and a sticky TRAP state for illegal or misaligned operations.
module mips_mc_core #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_run,
    mips_mc_core_if.master mem,
    output logic [31:0]    o_pc,
    output logic           o_retire,
    output logic           o_halted,
    input  logic [4:0]     i_dbg_addr,
    output logic [31:0]    o_dbg_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu_out, r_mdr;
    logic [31:0] r_regs [32];
    logic        r_mem_req, r_mem_we, r_halted;
    logic [31:0] r_mem_addr, r_mem_wdata;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wb_idx;
    logic        w_is_rtype, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j;
    logic        w_legal, w_misalign, w_mem_done;
    logic [31:0] w_alu_result, w_ea, w_ea_aligned, w_pc_plus4;
    logic [31:0] w_br_target, w_j_target, w_wb_data;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_is_rtype = (w_op == 6'b000000);
    assign w_is_addi  = (w_op == 6'b001000);
    assign w_is_lw    = (w_op == 6'b100011);
    assign w_is_sw    = (w_op == 6'b101011);
    assign w_is_beq   = (w_op == 6'b000100);
    assign w_is_j     = (w_op == 6'b000010);

    always_comb begin
        w_legal = w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_j;
        if (w_is_rtype) begin
            case (w_funct)
                6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_legal = 1'b1;
                default:                                               w_legal = 1'b0;
            endcase
        end
    end

    // addi shares the adder with R-type add; slt compares as signed
    always_comb begin
        w_alu_result = r_a + r_imm;
        if (w_is_rtype) begin
            case (w_funct)
                6'b100000: w_alu_result = r_a + r_b;
                6'b100010: w_alu_result = r_a - r_b;
                6'b100100: w_alu_result = r_a & r_b;
                6'b100101: w_alu_result = r_a | r_b;
                6'b101010: w_alu_result = {31'd0, $signed(r_a) < $signed(r_b)};
                default:   w_alu_result = 32'd0;
            endcase
        end
    end

    assign w_ea         = r_a + r_imm;
    assign w_misalign   = |w_ea[1:0];
    assign w_ea_aligned = {w_ea[31:2], 2'b00};
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_target  = w_pc_plus4 + {r_imm[29:0], 2'b00};
    assign w_j_target   = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
    assign w_mem_done   = r_mem_req & mem.ready;
    assign w_wb_idx     = w_is_rtype ? w_rd : w_rt;
    assign w_wb_data    = w_is_lw ? r_mdr : r_alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_alu_out   <= '0;
            r_mdr       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_halted    <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_run) begin
                    r_state    <= S_FETCH;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_pc;
                end
                S_FETCH: if (w_mem_done) begin
                    r_ir      <= mem.rdata;
                    r_mem_req <= 1'b0;
                    r_state   <= S_DECODE;
                end
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                    if (w_legal) r_state <= S_EXEC;
                    else begin
                        r_state  <= S_TRAP;
                        r_halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_beq) begin
                        r_pc    <= (r_a == r_b) ? w_br_target : w_pc_plus4;
                        r_state <= S_IDLE;
                    end else if (w_is_j) begin
                        r_pc    <= w_j_target;
                        r_state <= S_IDLE;
                    end else if (w_is_lw || w_is_sw) begin
                        r_alu_out <= w_ea_aligned;
                        // A misaligned access must not reach the bus at all
                        if (TRAP_ON_MISALIGN && w_misalign) begin
                            r_state  <= S_TRAP;
                            r_halted <= 1'b1;
                        end else begin
                            r_state     <= S_MEM;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_sw;
                            r_mem_addr  <= w_ea_aligned;
                            r_mem_wdata <= r_b;
                        end
                    end else begin
                        r_alu_out <= w_alu_result;
                        r_state   <= S_WB;
                    end
                end
                S_MEM: if (w_mem_done) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    if (w_is_sw) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= S_IDLE;
                    end else begin
                        r_mdr   <= mem.rdata;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_wb_idx != 5'd0) r_regs[w_wb_idx] <= w_wb_data;
                    r_pc    <= w_pc_plus4;
                    r_state <= S_IDLE;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // retire marks the cycle whose closing edge commits pc and register state
    assign o_retire = ((r_state == S_EXEC) && (w_is_beq || w_is_j)) ||
                      ((r_state == S_MEM) && w_mem_done && r_mem_we) ||
                      (r_state == S_WB);

    assign mem.req    = r_mem_req;
    assign mem.we     = r_mem_we;
    assign mem.addr   = r_mem_addr;
    assign mem.wdata  = r_mem_wdata;
    assign o_pc       = r_pc;
    assign o_halted   = r_halted;
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? 32'd0 : r_regs[i_dbg_addr];
endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: a wait-state memory model plus a queue of expected
// retirements (pc and cycle spacing) pushed while the program is loaded.
module tb_mips_mc_core;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [4:0]  dbgAddr = 5'd0;
    logic [31:0] dbgData, pcOut;
    logic        retire, halted;
    int          compared = 0;
    int          mismatched = 0;

    mips_mc_core_if memIf ();

    mips_mc_core #(.RESET_PC(RPC), .TRAP_ON_MISALIGN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (run),
        .mem        (memIf),
        .o_pc       (pcOut),
        .o_retire   (retire),
        .o_halted   (halted),
        .i_dbg_addr (dbgAddr),
        .o_dbg_data (dbgData)
    );

    always #5 clk = ~clk;

    logic [31:0] memArr [1024];
    int          waitStates = 0;
    int          waitCnt = 0;
    int          xferCount = 0;
    int          retireCount = 0;
    int          reqCycles = 0;
    int          unstableCount = 0;
    logic        firstSeen = 1'b0;
    logic [31:0] firstReqAddr = 32'd0;
    logic        prevWaiting = 1'b0;
    logic        prevWe = 1'b0;
    logic [31:0] prevAddr = 32'd0;
    logic [31:0] prevWdata = 32'd0;

    typedef struct {
        logic [31:0] pc;
        int          gap;
        int          waits;
    } exp_t;
    exp_t expQ[$];

    // Memory answers after waitStates cycles of a pending request
    always_comb begin
        memIf.ready = memIf.req && (waitCnt >= waitStates);
        memIf.rdata = (memIf.ready && !memIf.we) ? memArr[memIf.addr[11:2]] : 32'd0;
    end

    always @(posedge clk) begin
        waitCnt <= (memIf.req && !memIf.ready) ? waitCnt + 1 : 0;
        if (memIf.req && memIf.ready) begin
            xferCount <= xferCount + 1;
            if (memIf.we) memArr[memIf.addr[11:2]] <= memIf.wdata;
        end
        if (memIf.req) reqCycles <= reqCycles + 1;
        if (retire) retireCount <= retireCount + 1;
        if (prevWaiting && memIf.req &&
            (memIf.addr !== prevAddr || memIf.we !== prevWe || memIf.wdata !== prevWdata))
            unstableCount <= unstableCount + 1;
        prevWaiting <= memIf.req && !memIf.ready;
        prevAddr    <= memIf.addr;
        prevWe      <= memIf.we;
        prevWdata   <= memIf.wdata;
        if (!rst_n) firstSeen <= 1'b0;
        else if (memIf.req && !firstSeen) begin
            firstSeen    <= 1'b1;
            firstReqAddr <= memIf.addr;
        end
    end

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic holdReset();
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 1024; i++) memArr[i] = 32'd0;
    endtask

    task automatic queueInstr(input logic [31:0] addr, input logic [31:0] instr,
                              input int gap, input int waits);
        exp_t e;
        memArr[addr[11:2]] = instr;
        e.pc = addr;
        e.gap = gap;
        e.waits = waits;
        expQ.push_back(e);
    endtask

    task automatic waitRetire(input int maxEdges, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (edges < maxEdges && !seen) begin
            @(posedge clk);
            #1;
            edges++;
            if (retire) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got [7];
        logic [31:0] req [7];
        string       names [7];
        holdReset();
        got   = '{pcOut, {31'd0, memIf.req}, {31'd0, memIf.we}, memIf.addr, memIf.wdata,
                  {31'd0, retire}, {31'd0, halted}};
        req   = '{RPC, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        names = '{"reset_pc", "reset_req", "reset_we", "reset_addr", "reset_wdata",
                  "reset_retire", "reset_halted"};
        for (int i = 0; i < 7; i++) begin
            compared++;
            if (got[i] !== req[i]) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h expected %h", names[i], got[i], req[i]);
            end
        end
        for (int r = 0; r < 32; r++) begin
            dbgAddr = r[4:0];
            #1;
            compared++;
            if (dbgData !== 32'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 00000000", r, dbgData);
            end
        end
    endtask

    task automatic test_run_gate();
        int r0;
        r0 = reqCycles;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        compared++;
        if (reqCycles - r0 !== 0 || memIf.req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_no_req: got %0d req cycles expected 0", reqCycles - r0);
        end
        compared++;
        if (pcOut !== RPC) begin
            mismatched++;
            $display("[TB] FAIL idle_pc: got %h expected %h", pcOut, RPC);
        end
    endtask

    task automatic test_program();
        exp_t        e;
        int          edges;
        bit          seen;
        logic [31:0] expRegs [9];
        holdReset();
        queueInstr(32'h100, encI(6'b001000, 5'd0, 5'd1, 16'd5),      4, 0);
        queueInstr(32'h104, encI(6'b001000, 5'd0, 5'd2, 16'hFFFD),   5, 0);
        queueInstr(32'h108, encR(5'd1, 5'd2, 5'd3, 6'b100000),       5, 0);
        queueInstr(32'h10C, encR(5'd2, 5'd1, 5'd4, 6'b101010),       5, 0);
        queueInstr(32'h110, encR(5'd2, 5'd1, 5'd5, 6'b100010),       5, 0);
        queueInstr(32'h114, encI(6'b101011, 5'd0, 5'd1, 16'd8),     11, 3);
        queueInstr(32'h118, encI(6'b100011, 5'd0, 5'd6, 16'd8),     12, 3);
        queueInstr(32'h11C, encI(6'b001000, 5'd0, 5'd0, 16'd7),      5, 0);
        queueInstr(32'h120, encI(6'b000100, 5'd1, 5'd2, 16'd5),      4, 0);
        queueInstr(32'h124, {6'b000010, 26'h10},                     4, 0);
        queueInstr(32'h040, encI(6'b000100, 5'd1, 5'd6, 16'hFFFE),   4, 0);
        queueInstr(32'h03C, {6'b000010, 26'h20},                     4, 0);
        queueInstr(32'h080, encR(5'd5, 5'd1, 5'd7, 6'b100101),       5, 0);
        queueInstr(32'h084, encR(5'd1, 5'd6, 5'd8, 6'b100100),       5, 0);
        waitStates = 0;
        run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            waitStates = e.waits;
            waitRetire(40, edges, seen);
            if (expQ.size() == 0) run = 1'b0;
            compared++;
            if (!seen) begin
                mismatched++;
                $display("[TB] FAIL retire_timeout: no retire for pc %h within 40 cycles", e.pc);
            end else begin
                if (pcOut !== e.pc) begin
                    mismatched++;
                    $display("[TB] FAIL retire_pc: got %h expected %h", pcOut, e.pc);
                end
                compared++;
                if (edges != e.gap) begin
                    mismatched++;
                    $display("[TB] FAIL retire_gap pc %h: got %0d cycles expected %0d", e.pc, edges, e.gap);
                end
            end
        end
        waitStates = 0;
        repeat (10) @(posedge clk);
        #1;
        compared++;
        if (pcOut !== 32'h88 || memIf.req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL parked_pc: got %h req %b expected 00000088 req 0", pcOut, memIf.req);
        end
        compared++;
        if (firstReqAddr !== RPC) begin
            mismatched++;
            $display("[TB] FAIL first_fetch_addr: got %h expected %h", firstReqAddr, RPC);
        end
        compared++;
        if (memArr[2] !== 32'd5) begin
            mismatched++;
            $display("[TB] FAIL mem_word2: got %h expected 00000005", memArr[2]);
        end
        compared++;
        if (unstableCount !== 0) begin
            mismatched++;
            $display("[TB] FAIL bus_stable: got %0d changes expected 0", unstableCount);
        end
        expRegs = '{32'd0, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1, 32'hFFFF_FFF8,
                    32'd5, 32'hFFFF_FFFD, 32'd5};
        for (int r = 0; r < 9; r++) begin
            dbgAddr = r[4:0];
            #1;
            compared++;
            if (dbgData !== expRegs[r]) begin
                mismatched++;
                $display("[TB] FAIL reg%0d: got %h expected %h", r, dbgData, expRegs[r]);
            end
        end
    endtask

    task automatic test_trap(input logic [31:0] instr, input int expEdges, input string tag);
        int x0, r0, edges;
        holdReset();
        memArr[RPC[11:2]] = instr;
        waitStates = 0;
        run = 1'b1;
        x0 = xferCount;
        r0 = retireCount;
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        while (edges < 30 && !halted) begin
            @(posedge clk);
            #1;
            edges++;
        end
        compared++;
        if (!halted || edges != expEdges) begin
            mismatched++;
            $display("[TB] FAIL %s_halt_cycle: got halted=%b after %0d cycles expected 1 after %0d",
                     tag, halted, edges, expEdges);
        end
        repeat (10) @(posedge clk);
        #1;
        compared++;
        if (xferCount - x0 !== 1 || memIf.req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_no_data_req: got %0d transfers req %b expected 1 req 0",
                     tag, xferCount - x0, memIf.req);
        end
        compared++;
        if (retireCount - r0 !== 0) begin
            mismatched++;
            $display("[TB] FAIL %s_no_retire: got %0d retires expected 0", tag, retireCount - r0);
        end
        compared++;
        if (pcOut !== RPC || halted !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s_frozen: got pc %h halted %b expected %h halted 1",
                     tag, pcOut, halted, RPC);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if (halted !== 1'b0 || memIf.req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_async_reset: got halted %b req %b expected 0 0",
                     tag, halted, memIf.req);
        end
    endtask

    task automatic test_misalign();
        test_trap(encI(6'b100011, 5'd0, 5'd9, 16'd6), 4, "misalign");
    endtask

    task automatic test_illegal();
        test_trap({6'b111111, 26'd0}, 3, "illegal");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_run_gate();
        test_program();
        test_misalign();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_mc_core.md
# mips_mc_core

Multi-cycle 32-bit MIPS core: the successor to the single-cycle datapath (PC, instruction memory, tokenizer, registers, ALU, data memory, PC mux). It sequences fetch/decode/execute/memory/writeback with an FSM over one shared memory port with a valid/ready handshake, so any number of memory wait states is tolerated. It adds `addi`, a run/halt mode, retire reporting and a trap state for illegal or misaligned operations. It owns its 32×32 register file and sits between the test harness and one unified memory model.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_ON_MISALIGN, 1, 1: a misaligned lw/sw address traps; 0: low 2 address bits are forced to 0
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- run  in  1  level; 1 allows a new instruction fetch, 0 parks the core in IDLE between instructions
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write (sw), 0 = read
- mem_addr  out  32  byte address, word-aligned
- mem_wdata  out  32  store data (rt)
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  32  read data, valid when mem_req & mem_ready & !mem_we
- pc  out  32  address of the current/next instruction
- retire  out  1  one-cycle pulse in an instruction's final cycle
- halted  out  1  core is in TRAP
- dbg_addr  in  5  register-file debug read address
- dbg_data  out  32  combinational read of register dbg_addr ($0 reads 0)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: if run=1, go to FETCH, else stay. FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready, then latch IR and go to DECODE.
- DECODE: latch A=R[rs], B=R[rt], sign-extended imm; illegal opcode/funct goes to TRAP.
- Supported: R-type funct add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed); addi 001000; lw 100011; sw 101011; beq 000100; j 000010. Anything else is illegal.
- EXEC:
  - R-type/addi: ALUOut = result, go to WB.
  - lw/sw: ALUOut = A + sext(imm), go to MEM.
  - beq: pc = (A==B) ? pc+4+(sext(imm)<<2) : pc+4; retire; go to IDLE.
  - j: pc = {pc_plus4[31:28], IR[25:0], 2'b00}; retire; go to IDLE.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B; hold until mem_ready. sw: pc+=4, retire, go to IDLE. lw: latch MDR, go to WB.
- WB: write R[rd] (R-type), R[rt] (addi) or MDR (lw); pc+=4; retire; go to IDLE.
- Writes to $0 are discarded; $0 always reads 0.
- Arithmetic is modulo 2^32 with no overflow exception. pc wraps from 32'hFFFF_FFFC to 0.
- Misaligned lw/sw (ALUOut[1:0]≠0) with TRAP_ON_MISALIGN=1: EXEC goes to TRAP and no memory request is issued.
- TRAP: halted=1, mem_req=0, pc frozen at the faulting instruction; exit only via reset.
- Dropping run mid-instruction has no effect; it is sampled only in IDLE.

## Timing
- Reset (async assert, sync-to-CLK deassert use): state=IDLE, pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0, all registers 0.
- A memory transfer completes in the cycle with mem_req & mem_ready. mem_addr/mem_we/mem_wdata are stable while mem_req=1 and not ready. mem_ready with mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the first request cycle), excluding the IDLE cycle: beq/j 3, R-type/addi 4, sw 4, lw 5. Each wait state adds 1.
- Every instruction passes through one IDLE cycle, so continuous run adds +1 to each count.
- retire and the architectural update (pc, register write) happen in the same cycle. The new pc is visible the next cycle.
- Reset asserted mid-transaction drops mem_req immediately and discards the partial instruction.

## Test plan
- Reset with RESET_PC=32'h100, run=1, zero-wait memory → first mem_req has addr 32'h100, and the first retire occurs 5 cycles after reset release (1 IDLE + 4 for an R-type).
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sub $5,$2,$1 → dbg reads $3=2, $4=1, $5=32'hFFFF_FFF8.
- sw $1,8($0) then lw $6,8($0) with 3 wait states on every access → memory word 2 = 5, $6=5, lw takes 5+6=11 cycles (fetch and load each wait 3).
- beq taken (offset -2) and not taken, j to 0x40 → pc sequence matches, 3 cycles each; addi $0,$0,7 → $0 stays 0.
- lw at address 6 with TRAP_ON_MISALIGN=1 → halted=1, no data request, pc holds; then drop RST_N mid-trap → halted=0 asynchronously.
- Illegal opcode 6'b111111 → TRAP after DECODE, retire never pulses; run=0 in IDLE → mem_req stays 0 indefinitely.
